// File: rtl/masked_weighted_ranks.sv
// Sliding-window weighted rank engine.
// Keeps an N x N comparison matrix for the last N samples. Each accepted
// vector shifts a new row into the matrix. The block then outputs, for every
// slot, the masked and weighted count of slots that it beats, together with
// the total masked weight.
module masked_weighted_ranks #(
    parameter  int N  = 7,
    parameter  int W  = 4,
    localparam int RB = $clog2(N*(2**W-1)+1),
    localparam int CB = $clog2(N+1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-2:0]    gts,
    input  logic [N-1:0]    mask,
    input  logic [N*W-1:0]  weights,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N*RB-1:0] ranks_out,
    output logic [RB-1:0]   total_weight,
    output logic            window_full
);

    logic [N-1:0]    m_q [N];
    logic [N-1:0]    m_d [N];
    logic [N-1:0]    m_next [N];
    logic [CB-1:0]   fill_q, fill_d, fill_inc;
    logic            out_valid_q, out_valid_d;
    logic [N*RB-1:0] ranks_q, ranks_d, ranks_calc;
    logic [RB-1:0]   total_q, total_d, total_calc;
    logic            accept;

    // Empty-window pattern: row j has its low j+1 bits set.
    function automatic logic [N-1:0] init_row(input int j);
        logic [N-1:0] r;
        r = '0;
        for (int b = 0; b < N; b++) r[b] = (b <= j);
        return r;
    endfunction

    assign in_ready     = !flush && (!out_valid_q || out_ready);
    assign accept       = in_valid && in_ready;
    assign out_valid    = out_valid_q;
    assign ranks_out    = ranks_q;
    assign total_weight = total_q;
    assign window_full  = (fill_q == CB'(N));
    assign fill_inc     = (fill_q == CB'(N)) ? fill_q : fill_q + CB'(1);

    // Matrix after the incoming vector is shifted in (oldest row drops out).
    always_comb begin
        for (int i = 0; i < N-1; i++) m_next[i] = {~gts[i], m_q[i+1][N-1:1]};
        m_next[N-1] = {1'b1, gts};
    end

    // Masked weighted ranks of the shifted matrix, plus the masked weight total.
    always_comb begin
        total_calc = '0;
        ranks_calc = '0;
        for (int k = 0; k < N; k++) begin
            if (mask[k]) total_calc = total_calc + RB'(weights[k*W +: W]);
        end
        for (int j = 0; j < N; j++) begin
            if (mask[j]) begin
                for (int k = 0; k < N; k++) begin
                    if (m_next[j][k] && mask[k])
                        ranks_calc[j*RB +: RB] = ranks_calc[j*RB +: RB] + RB'(weights[k*W +: W]);
                end
            end
        end
    end

    // Next-state selection; flush overrides accept, and accept overrides consume.
    always_comb begin
        m_d         = m_q;
        fill_d      = fill_q;
        out_valid_d = out_valid_q;
        ranks_d     = ranks_q;
        total_d     = total_q;
        if (flush) begin
            for (int j = 0; j < N; j++) m_d[j] = init_row(j);
            fill_d      = '0;
            out_valid_d = 1'b0;
        end else if (accept) begin
            m_d         = m_next;
            fill_d      = fill_inc;
            out_valid_d = (fill_inc == CB'(N));
            ranks_d     = ranks_calc;
            total_d     = total_calc;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int j = 0; j < N; j++) m_q[j] <= init_row(j);
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            ranks_q     <= '0;
            total_q     <= '0;
        end else begin
            m_q         <= m_d;
            fill_q      <= fill_d;
            out_valid_q <= out_valid_d;
            ranks_q     <= ranks_d;
            total_q     <= total_d;
        end
    end

endmodule

// File: doc/masked_weighted_ranks.md
MASKED_WEIGHTED_RANKS -- requirements
Module: masked_weighted_ranks

Interface
REQ-001 Parameter N, default 7: window length in samples, N >= 3.
REQ-002 Parameter W, default 4: weight width in bits, W >= 1.
REQ-003 Derived RB = $clog2(N*(2**W-1)+1): width of one weighted rank; derived CB = $clog2(N+1): fill-counter width.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 flush  in  1  synchronous window clear.
REQ-007 in_valid  in  1  new comparison vector present.
REQ-008 in_ready  out  1  block accepts gts this cycle.
REQ-009 gts  in  N-1  bit i = new sample greater than sample in slot i (slot 0 oldest).
REQ-010 mask  in  N  per-slot enable, sampled at acceptance.
REQ-011 weights  in  N*W  slot k weight at [k*W +: W], unsigned, sampled at acceptance.
REQ-012 out_valid  out  1  ranks_out/total_weight hold a valid result.
REQ-013 out_ready  in  1  downstream consumes result.
REQ-014 ranks_out  out  N*RB  slot j weighted rank at [j*RB +: RB].
REQ-015 total_weight  out  RB  sum of masked weights for the result.
REQ-016 window_full  out  1  fill_cnt == N.

Function
REQ-017 Internal state: N rows M[0..N-1] of N bits, fill_cnt (CB bits), output register (ranks_out, total_weight, out_valid).
REQ-018 in_ready = !flush && (!out_valid || out_ready); accept = in_valid && in_ready.
REQ-019 On accept, M updates: M[N-1] <= {1'b1, gts}; for i in 0..N-2, M[i] <= {~gts[i], M[i+1][N-1:1]}. Without accept, M holds.
REQ-020 Weighted rank of slot j from a matrix X: r_j = mask[j] ? sum over k of (X[j][k] & mask[k]) * weight[k] : 0, computed at full RB width with no overflow.
REQ-021 total_weight = sum over k of mask[k]*weight[k].
REQ-022 On accept, the output register loads r_j and total_weight computed from the next-state matrix and the current mask/weights; latency is exactly 1 cycle from the accepting edge.
REQ-023 On accept, fill_cnt <= min(fill_cnt+1, N); it saturates at N.
REQ-024 out_valid rises the cycle after an accept whose post-increment fill_cnt == N; accepts that leave fill_cnt < N update M but do not set out_valid.
REQ-025 out_valid, once set, holds with ranks_out/total_weight stable until out_ready is high; out_valid && out_ready without a new accept clears out_valid.
REQ-026 Simultaneous consume and accept (out_ready=1, accept=1, window full) reloads the output and keeps out_valid=1, with no bubble.
REQ-027 When out_valid=1 and out_ready=0, in_ready=0 and gts is not accepted (backpressure).
REQ-028 flush=1: M[j] <= 2**(j+1)-1, fill_cnt <= 0, out_valid <= 0, in_ready=0; in_valid that cycle is dropped; flush has priority over all other events.
REQ-029 ranks_out/total_weight hold their last values when out_valid=0; only out_valid qualifies them.

Reset
REQ-030 rst low asynchronously forces M[j] = 2**(j+1)-1, fill_cnt=0, out_valid=0, ranks_out=0, total_weight=0; window_full=0.
REQ-031 Reset mid-transfer discards the pending result; the first accept after rst rises restarts the fill from 0.

Verification
REQ-032 N=3, W=2, mask=111, weights all 1: reset, accept gts=00 twice -> no out_valid; the third accept of gts=00 -> next cycle out_valid=1, window_full=1, total_weight=3.
REQ-033 Same config after reset: load fill_cnt to 2 with accepts, then apply a third accept whose M_next rows are 101/111/100 -> ranks_out slots 0,1,2 = 2,3,1 (recompute against the REQ-019 model).
REQ-034 Full window, out_valid=1, out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, outputs stable, M unchanged; out_ready=1 -> in_ready=1, result reloads next cycle, no bubble.
REQ-035 Full window, mask=101, weights={3,2,1} (slot2..0) -> rank of slot 1 = 0, total_weight=4, remaining ranks match the REQ-020 model.
REQ-036 flush asserted together with in_valid mid-stream -> sample dropped, out_valid=0 next cycle, fill_cnt=0, M equals reset pattern; N further accepts are required before out_valid.
REQ-037 Random gts/mask/weights/out_ready for 10k cycles, N=7, W=4 -> scoreboard against the REQ-019/REQ-020 reference model with no mismatch.
